// File: rtl/dbg_disp_pkg.sv
// ---------------------------------------------------------------------------
// dbg_disp_pkg
// Shared definitions for the VGA debug-screen row mapper.
//   - state_e     : band-tracker states
//   - DEF_*       : default screen layout (channel count, widths, row heights)
//   - calc_idx_w  : width of a channel index, never less than 1
//   - calc_cnt_w  : width of the shared row counter for a given layout
// ---------------------------------------------------------------------------
package dbg_disp_pkg;

    localparam int unsigned DEF_NUM_CH = 14;
    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_TOP    = 25;
    localparam int unsigned DEF_BAND_H = 31;
    localparam int unsigned DEF_GAP_H  = 9;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_TOP  = 3'd1,
        S_BAND = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // A single channel still needs a 1-bit index port.
    function automatic int unsigned calc_idx_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    // The counter must be able to hold the tallest of the three row runs.
    function automatic int unsigned calc_cnt_w(input int unsigned top,
                                               input int unsigned band_h,
                                               input int unsigned gap_h);
        int unsigned m;
        m = top;
        if (band_h > m) m = band_h;
        if (gap_h > m)  m = gap_h;
        return $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/dbg_band_tracker.sv
// ---------------------------------------------------------------------------
// dbg_band_tracker
// Follows the scan position from frame/line strobes with one row counter and
// one channel counter (no per-row comparators). Exposes the state that will
// be in effect after the current clock edge so the top level can register
// its outputs on the very edge that samples the strobe.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   i_frame_start     : row 0 of a new frame (wins over i_line_start)
//   i_line_start      : advance one row
//   o_nxt_in_band     : next row lies inside a channel band
//   o_nxt_ch          : channel index in effect after this edge
// ---------------------------------------------------------------------------
module dbg_band_tracker
    import dbg_disp_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned TOP    = DEF_TOP,
    parameter int unsigned BAND_H = DEF_BAND_H,
    parameter int unsigned GAP_H  = DEF_GAP_H
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_frame_start,
    input  logic                             i_line_start,
    output logic                             o_nxt_in_band,
    output logic [calc_idx_w(NUM_CH)-1:0]    o_nxt_ch
);

    localparam int unsigned IDX_W = calc_idx_w(NUM_CH);
    localparam int unsigned CNT_W = calc_cnt_w(TOP, BAND_H, GAP_H);

    localparam logic [CNT_W-1:0] TOP_C   = CNT_W'(TOP);
    localparam logic [CNT_W-1:0] BAND_C  = CNT_W'(BAND_H);
    localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_H);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] CH_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] CH_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] CH_LAST = IDX_W'(NUM_CH - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_ch;

    state_e             w_nxt_state;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic [IDX_W-1:0]   w_nxt_ch;

    // Next-state logic: the counter always holds "rows consumed in the
    // current run", so a run ends when it equals the run height.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_ch    = r_ch;
        if (i_frame_start) begin
            w_nxt_state = S_TOP;
            w_nxt_cnt   = CNT_ONE;
            w_nxt_ch    = CH_ZERO;
        end else if (i_line_start) begin
            case (r_state)
                S_TOP: begin
                    if (r_cnt == TOP_C) begin
                        w_nxt_state = S_BAND;
                        w_nxt_ch    = CH_ZERO;
                        w_nxt_cnt   = CNT_ONE;
                    end else begin
                        w_nxt_cnt   = r_cnt + CNT_ONE;
                    end
                end
                S_BAND: begin
                    if (r_cnt == BAND_C) begin
                        w_nxt_state = (r_ch == CH_LAST) ? S_DONE : S_GAP;
                        w_nxt_cnt   = CNT_ONE;
                    end else begin
                        w_nxt_cnt   = r_cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_C) begin
                        w_nxt_state = S_BAND;
                        w_nxt_ch    = r_ch + CH_ONE;
                        w_nxt_cnt   = CNT_ONE;
                    end else begin
                        w_nxt_cnt   = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    // S_IDLE waits for a frame, S_DONE waits for the next one.
                    w_nxt_state = r_state;
                end
            endcase
        end else begin
            w_nxt_state = r_state;
        end
    end

    // Tracker state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_ch    <= {IDX_W{1'b0}};
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_ch    <= w_nxt_ch;
        end
    end

    assign o_nxt_in_band = (w_nxt_state == S_BAND);
    assign o_nxt_ch      = w_nxt_ch;

endmodule

// File: rtl/dbg_row_mux.sv
// ---------------------------------------------------------------------------
// dbg_row_mux
// Maps each scan line of the VGA debug screen to one captured debug channel
// or to blank. All channels are snapshotted into a shadow bank at every
// frame_start so a frame never mixes pipeline states.
// Optional feature macro: DBG_ROW_FREEZE_EN adds the freeze input, which
// suppresses the shadow recapture at frame_start for single-step viewing.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   frame_start  : current line is row 0 of a new frame
//   line_start   : next row begins
//   ch_data      : packed channels, channel k at [k*DATA_W +: DATA_W]
//   freeze       : (DBG_ROW_FREEZE_EN only) hold the shadow bank
//   data         : channel value for the current row, 0 when blank
//   all          : 1 when the current row shows no channel
//   ch_idx       : last displayed channel index
// ---------------------------------------------------------------------------
module dbg_row_mux
    import dbg_disp_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TOP    = DEF_TOP,
    parameter int unsigned BAND_H = DEF_BAND_H,
    parameter int unsigned GAP_H  = DEF_GAP_H
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           line_start,
    input  logic [NUM_CH*DATA_W-1:0]       ch_data,
`ifdef DBG_ROW_FREEZE_EN
    input  logic                           freeze,
`endif
    output logic [DATA_W-1:0]              data,
    output logic                           all,
    output logic [calc_idx_w(NUM_CH)-1:0]  ch_idx
);

    localparam int unsigned IDX_W = calc_idx_w(NUM_CH);

    logic [NUM_CH*DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0]        r_data;
    logic                     r_all;
    logic [IDX_W-1:0]         r_ch_idx;

    logic                     w_capture;
    logic                     w_nxt_in_band;
    logic [IDX_W-1:0]         w_nxt_ch;
    logic [DATA_W-1:0]        w_sel;

    dbg_band_tracker #(
        .NUM_CH (NUM_CH),
        .TOP    (TOP),
        .BAND_H (BAND_H),
        .GAP_H  (GAP_H)
    ) u_tracker (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (frame_start),
        .i_line_start  (line_start),
        .o_nxt_in_band (w_nxt_in_band),
        .o_nxt_ch      (w_nxt_ch)
    );

    // Decide whether this frame_start refreshes the shadow bank.
    always_comb begin
`ifdef DBG_ROW_FREEZE_EN
        w_capture = frame_start & ~freeze;
`else
        w_capture = frame_start;
`endif
    end

    // Shadow bank: one snapshot of every channel per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow <= {(NUM_CH*DATA_W){1'b0}};
        end else if (w_capture) begin
            r_shadow <= ch_data;
        end else begin
            r_shadow <= r_shadow;
        end
    end

    // AND-OR channel select; indices beyond NUM_CH-1 never match and give 0.
    always_comb begin
        w_sel = {DATA_W{1'b0}};
        for (int k = 0; k < int'(NUM_CH); k++) begin
            w_sel = w_sel | (r_shadow[k*DATA_W +: DATA_W]
                             & {DATA_W{(w_nxt_ch == IDX_W'(k))}});
        end
    end

    // Output registers: only strobe edges change what the row shows; during
    // a band the value comes from the bank captured at frame_start, which
    // cannot differ from the pre-edge bank because frame_start itself lands
    // outside any band.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= {DATA_W{1'b0}};
            r_all    <= 1'b1;
            r_ch_idx <= {IDX_W{1'b0}};
        end else if (frame_start || line_start) begin
            if (w_nxt_in_band) begin
                r_data   <= w_sel;
                r_all    <= 1'b0;
                r_ch_idx <= w_nxt_ch;
            end else begin
                r_data   <= {DATA_W{1'b0}};
                r_all    <= 1'b1;
                r_ch_idx <= r_ch_idx;
            end
        end else begin
            r_data   <= r_data;
            r_all    <= r_all;
            r_ch_idx <= r_ch_idx;
        end
    end

    assign data   = r_data;
    assign all    = r_all;
    assign ch_idx = r_ch_idx;

endmodule

// File: tb/tb_dbg_row_mux.sv
// ---------------------------------------------------------------------------
// tb_dbg_row_mux
// Drives a default-layout instance (u_a) and a tiny-layout instance (u_b:
// NUM_CH=3, DATA_W=8, TOP=1, BAND_H=2, GAP_H=1) from shared strobes. The
// reference keeps only "row number since frame_start" plus a per-frame
// snapshot of the channels, and derives the band from plain division.
// ---------------------------------------------------------------------------
module tb_dbg_row_mux;

    logic         clk = 1'b0;
    logic         reset;
    logic         fs;
    logic         ls;
    logic [223:0] ch_a;
    logic [23:0]  ch_b;
    logic [15:0]  d_a;
    logic         all_a;
    logic [3:0]   idx_a;
    logic [7:0]   d_b;
    logic         all_b;
    logic [1:0]   idx_b;
`ifdef DBG_ROW_FREEZE_EN
    logic         frz = 1'b0;
`endif

    always #5 clk = ~clk;

    dbg_row_mux u_a (
        .clk(clk), .reset(reset), .frame_start(fs), .line_start(ls),
        .ch_data(ch_a),
`ifdef DBG_ROW_FREEZE_EN
        .freeze(frz),
`endif
        .data(d_a), .all(all_a), .ch_idx(idx_a)
    );

    dbg_row_mux #(.NUM_CH(3), .DATA_W(8), .TOP(1), .BAND_H(2), .GAP_H(1)) u_b (
        .clk(clk), .reset(reset), .frame_start(fs), .line_start(ls),
        .ch_data(ch_b),
`ifdef DBG_ROW_FREEZE_EN
        .freeze(frz),
`endif
        .data(d_b), .all(all_b), .ch_idx(idx_b)
    );

    // ---------------- reference model ----------------
    bit          m_started = 1'b0;
    int          m_row     = 0;
    logic [15:0] snap_a [14];
    logic [7:0]  snap_b [3];
    int          last_a    = 0;
    int          last_b    = 0;

    // Band shown on a given row, -1 when blank.
    function automatic int band_of(int row, int top, int bh, int gh, int nch);
        int rr;
        int b;
        if (row < top) return -1;
        rr = row - top;
        b  = rr / (bh + gh);
        if (b >= nch) return -1;
        if ((rr % (bh + gh)) >= bh) return -1;
        return b;
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_row     = 0;
        last_a    = 0;
        last_b    = 0;
        for (int k = 0; k < 14; k++) snap_a[k] = 16'h0000;
        for (int k = 0; k < 3; k++)  snap_b[k] = 8'h00;
    endtask

    task automatic model_edge(input logic f, input logic l);
        int b;
        if (f) begin
            m_started = 1'b1;
            m_row     = 0;
`ifdef DBG_ROW_FREEZE_EN
            if (!frz) begin
`else
            begin
`endif
                for (int k = 0; k < 14; k++) snap_a[k] = ch_a[k*16 +: 16];
                for (int k = 0; k < 3; k++)  snap_b[k] = ch_b[k*8 +: 8];
            end
        end else if (l && m_started) begin
            m_row++;
        end
        if (m_started) begin
            b = band_of(m_row, 25, 31, 9, 14);
            if (b >= 0) last_a = b;
            b = band_of(m_row, 1, 2, 1, 3);
            if (b >= 0) last_b = b;
        end
    endtask

    // ---------------- pinned literal expectations ----------------
    int          pin_req = 0;
    int          pin_ack = 0;
    bit          pin_dut;
    logic [15:0] pin_d;
    logic        pin_all;
    int          pin_idx;

    task automatic pin(input bit dut, input logic [15:0] d, input logic a, input int idx);
        pin_dut = dut;
        pin_d   = d;
        pin_all = a;
        pin_idx = idx;
        pin_req++;
    endtask

    // ---------------- compare process ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (row %0d, t=%0t)", nm, act, exp, m_row, $time);
        end
    endtask

    // Check both instances against the model on every falling edge.
    always @(negedge clk) begin
        int b_a;
        int b_b;
        b_a = m_started ? band_of(m_row, 25, 31, 9, 14) : -1;
        b_b = m_started ? band_of(m_row, 1, 2, 1, 3) : -1;
        chk("data_a", {16'h0, d_a}, (b_a < 0) ? 32'h0 : {16'h0, snap_a[b_a]});
        chk("all_a",  {31'h0, all_a}, (b_a < 0) ? 32'h1 : 32'h0);
        chk("idx_a",  {28'h0, idx_a}, last_a);
        chk("data_b", {24'h0, d_b}, (b_b < 0) ? 32'h0 : {24'h0, snap_b[b_b]});
        chk("all_b",  {31'h0, all_b}, (b_b < 0) ? 32'h1 : 32'h0);
        chk("idx_b",  {30'h0, idx_b}, last_b);
        if (pin_req != pin_ack) begin
            if (!pin_dut) begin
                chk("pin_data_a", {16'h0, d_a}, {16'h0, pin_d});
                chk("pin_all_a",  {31'h0, all_a}, {31'h0, pin_all});
                chk("pin_idx_a",  {28'h0, idx_a}, pin_idx);
            end else begin
                chk("pin_data_b", {24'h0, d_b}, {16'h0, pin_d});
                chk("pin_all_b",  {31'h0, all_b}, {31'h0, pin_all});
                chk("pin_idx_b",  {30'h0, idx_b}, pin_idx);
            end
            pin_ack = pin_req;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic f, input logic l);
        fs = f;
        ls = l;
        @(posedge clk);
        if (!reset) model_edge(f, l);
        #2;
        fs = 1'b0;
        ls = 1'b0;
    endtask

    task automatic adv_to(input int row);
        while (m_row < row) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1;
        fs    = 1'b0;
        ls    = 1'b0;
        model_reset();
        for (int k = 0; k < 14; k++) ch_a[k*16 +: 16] = 16'hA000 + 16'(k);
        for (int k = 0; k < 3; k++)  ch_b[k*8 +: 8]   = 8'h10 + 8'(k);
        pin(1'b0, 16'h0000, 1'b1, 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // line_start before any frame_start is ignored
        repeat (5) cyc(1'b0, 1'b1);
        pin(1'b0, 16'h0000, 1'b1, 0);

        // Frame 1: layout walk on both instances
        cyc(1'b1, 1'b0);
        pin(1'b0, 16'h0000, 1'b1, 0);
        adv_to(1);   pin(1'b1, 16'h0010, 1'b0, 0);
        adv_to(3);   pin(1'b1, 16'h0000, 1'b1, 0);
        adv_to(7);   pin(1'b1, 16'h0012, 1'b0, 2);
        adv_to(9);   pin(1'b1, 16'h0000, 1'b1, 2);
        adv_to(24);  pin(1'b0, 16'h0000, 1'b1, 0);
        adv_to(25);  pin(1'b0, 16'hA000, 1'b0, 0);
        adv_to(30);  ch_a[15:0] = 16'h1234;
        adv_to(55);  pin(1'b0, 16'hA000, 1'b0, 0);
        adv_to(56);  pin(1'b0, 16'h0000, 1'b1, 0);
        adv_to(65);  pin(1'b0, 16'hA001, 1'b0, 1);
        adv_to(545); pin(1'b0, 16'hA00D, 1'b0, 13);
        adv_to(575); pin(1'b0, 16'hA00D, 1'b0, 13);
        adv_to(576); pin(1'b0, 16'h0000, 1'b1, 13);
        adv_to(600); pin(1'b0, 16'h0000, 1'b1, 13);

        // Frame 2: new snapshot, then frame_start colliding with line_start
        cyc(1'b1, 1'b0);
        adv_to(25);  pin(1'b0, 16'h1234, 1'b0, 0);
        adv_to(40);
        cyc(1'b1, 1'b1);
        pin(1'b0, 16'h0000, 1'b1, 0);
        repeat (24) cyc(1'b0, 1'b1);
        pin(1'b0, 16'h0000, 1'b1, 0);
        cyc(1'b0, 1'b1);
        pin(1'b0, 16'h1234, 1'b0, 0);

        // Frame 3: asynchronous reset in the middle of band 1
        cyc(1'b1, 1'b0);
        adv_to(70);  pin(1'b0, 16'hA001, 1'b0, 1);
        cyc(1'b0, 1'b0);
        reset = 1'b1;
        model_reset();
        pin(1'b0, 16'h0000, 1'b1, 0);
        repeat (3) cyc(1'b0, 1'b1);
        reset = 1'b0;
        repeat (30) cyc(1'b0, 1'b1);
        pin(1'b0, 16'h0000, 1'b1, 0);

`ifdef DBG_ROW_FREEZE_EN
        // Freeze holds the old snapshot across a frame_start
        ch_a[15:0] = 16'h1234;
        cyc(1'b1, 1'b0);
        adv_to(25);  pin(1'b0, 16'h1234, 1'b0, 0);
        frz = 1'b1;
        ch_a[15:0] = 16'h5678;
        cyc(1'b1, 1'b0);
        adv_to(25);  pin(1'b0, 16'h1234, 1'b0, 0);
        frz = 1'b0;
        cyc(1'b1, 1'b0);
        adv_to(25);  pin(1'b0, 16'h5678, 1'b0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 49) == 0)
                ch_a[$urandom_range(0, 13)*16 +: 16] = 16'($urandom);
            if ($urandom_range(0, 29) == 0)
                ch_b[$urandom_range(0, 2)*8 +: 8] = 8'($urandom);
`ifdef DBG_ROW_FREEZE_EN
            if ($urandom_range(0, 199) == 0) frz = ~frz;
`endif
            cyc(($urandom_range(0, 899) == 0) || (i == 0),
                ($urandom_range(0, 3) != 0));
        end

        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
